// File: rtl/sm4_pipe_sched.sv
// Shares one free-running 34-cycle SM4 pipeline between requesters A and B.
// Credit-gated round-robin issue, owner tags that ride alongside the pipeline, per-requester result FIFOs.

module sm4_pipe_sched_lane #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         issue_i,
  input  logic         ret_i,
  input  logic [127:0] ret_data_i,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output logic [127:0] out_data_o,
  output logic         credit_ok_o
);
  localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DW   = CW + 1;
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [CW:0]   DEPTH_W = DW'(DEPTH);

  logic [DEPTH-1:0][127:0] mem_q;
  logic [AW-1:0]           wr_q, rd_q;
  logic [CW-1:0]           cnt_q, cnt_d, inf_q, inf_d;
  logic [CW:0]             used;
  logic                    pop;

  assign out_valid_o = (cnt_q != '0);
  assign out_data_o  = out_valid_o ? mem_q[rd_q] : '0;
  assign pop         = out_valid_o && out_ready_i;
  // Blocks still in the pipeline already own a FIFO slot.
  assign used        = {1'b0, cnt_q} + {1'b0, inf_q};
  assign credit_ok_o = (used < DEPTH_W);

  always_comb begin
    cnt_d = cnt_q;
    inf_d = inf_q;
    if (ret_i && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!ret_i && pop) cnt_d = cnt_q - 1'b1;
    if (issue_i && !ret_i)      inf_d = inf_q + 1'b1;
    else if (!issue_i && ret_i) inf_d = inf_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      inf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      inf_q <= inf_d;
      if (ret_i) wr_q <= (wr_q == LAST) ? '0 : wr_q + 1'b1;
      if (pop)   rd_q <= (rd_q == LAST) ? '0 : rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ret_i) mem_q[wr_q] <= ret_data_i;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) used <= DEPTH_W);
endmodule

module sm4_pipe_sched #(
  parameter int LAT        = 34,
  parameter int OBUF_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         a_in_valid,
  output logic         a_in_ready,
  input  logic [127:0] a_in_data,
  input  logic         b_in_valid,
  output logic         b_in_ready,
  input  logic [127:0] b_in_data,
  output logic [127:0] pipe_data,
  input  logic [127:0] pipe_dataout,
  output logic         a_out_valid,
  input  logic         a_out_ready,
  output logic [127:0] a_out_data,
  output logic         b_out_valid,
  input  logic         b_out_ready,
  output logic [127:0] b_out_data
);
  localparam int CW   = $clog2(OBUF_DEPTH + 1);
  localparam int NREQ = 2;

  logic [NREQ-1:0]        in_valid, credit_ok, elig, grant, ret, out_ready, out_valid;
  logic [NREQ-1:0][127:0] in_data, out_data;
  logic                   ptr_q, ptr_d;
  logic [127:0]           pipe_data_q;
  logic [LAT:0]           vld_pipe, id_pipe;

  assign in_valid  = {b_in_valid, a_in_valid};
  assign in_data   = {b_in_data, a_in_data};
  assign out_ready = {b_out_ready, a_out_ready};
  // rstn gate keeps ready low while reset is held, even with valid asserted.
  assign elig      = in_valid & credit_ok & {NREQ{rstn}};

  // ptr_q=1 favours B on contention.
  always_comb begin
    grant = '0;
    if (elig[0] && (!elig[1] || !ptr_q)) grant[0] = 1'b1;
    else if (elig[1])                    grant[1] = 1'b1;
    ptr_d = ptr_q;
    if (grant[0])      ptr_d = 1'b1;
    else if (grant[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q       <= 1'b0;
      pipe_data_q <= '0;
      vld_pipe    <= '0;
      id_pipe     <= '0;
    end else begin
      ptr_q    <= ptr_d;
      vld_pipe <= {vld_pipe[LAT-1:0], |grant};
      id_pipe  <= {id_pipe[LAT-1:0], grant[1]};
      if (|grant) pipe_data_q <= grant[1] ? in_data[1] : in_data[0];
    end
  end

  // Stage LAT holds the tag of the block whose result is on pipe_dataout now.
  assign ret[0] = vld_pipe[LAT] & ~id_pipe[LAT];
  assign ret[1] = vld_pipe[LAT] &  id_pipe[LAT];

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    sm4_pipe_sched_lane #(.DEPTH(OBUF_DEPTH), .CW(CW)) u_lane (
      .clk         (clk),
      .rstn        (rstn),
      .issue_i     (grant[i]),
      .ret_i       (ret[i]),
      .ret_data_i  (pipe_dataout),
      .out_ready_i (out_ready[i]),
      .out_valid_o (out_valid[i]),
      .out_data_o  (out_data[i]),
      .credit_ok_o (credit_ok[i])
    );
  end

  assign a_in_ready  = grant[0];
  assign b_in_ready  = grant[1];
  assign pipe_data   = pipe_data_q;
  assign a_out_valid = out_valid[0];
  assign b_out_valid = out_valid[1];
  assign a_out_data  = out_data[0];
  assign b_out_data  = out_data[1];
endmodule
